// File: rtl/gf2_row_systemizer_if.sv
// gf2_row_systemizer_if: control, status and row-access bundle for the
// GF(2) row systemizer.
//   start    - request a reduction run (honoured only while idle)
//   busy     - engine is running or still reporting completion
//   done     - one-cycle completion pulse
//   success  - last run reduced the square part to identity
//   fail     - last run hit a column with no pivot (singular)
//   wr_en / wr_addr / data_in   - row write port (idle only)
//   rd_en / rd_addr / data_out  - row read port (any state, 1-cycle latency)
// The master modport belongs to whoever drives the engine; the slave modport
// belongs to the engine itself.
interface gf2_row_systemizer_if #(
  parameter int ROWS = 8,
  parameter int COLS = 10,
  parameter int AW   = (ROWS > 1) ? $clog2(ROWS) : 1
);
  logic            start;
  logic            busy;
  logic            done;
  logic            success;
  logic            fail;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [COLS-1:0] data_in;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic [COLS-1:0] data_out;

  modport master (
    output start, wr_en, wr_addr, data_in, rd_en, rd_addr,
    input  busy, done, success, fail, data_out
  );

  modport slave (
    input  start, wr_en, wr_addr, data_in, rd_en, rd_addr,
    output busy, done, success, fail, data_out
  );
endinterface

// File: rtl/gf2_row_systemizer.sv
// gf2_row_systemizer: GF(2) Gaussian-elimination engine. Holds a ROWS x COLS
// bit matrix and, on start, reduces the left ROWS x ROWS block to identity
// using pivot search, row swap and parallel elimination of the pivot column.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset (clears matrix and all status)
//   bus  - gf2_row_systemizer_if slave modport (control, status, row access)
module gf2_row_systemizer #(
  parameter int ROWS = 8,
  parameter int COLS = 10,
  parameter int AW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  gf2_row_systemizer_if.slave  bus
);

  localparam int            CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [AW-1:0] LAST = AW'(ROWS - 1);

  typedef enum logic [2:0] {IDLE, SEARCH, SWAP, ELIM, FIN} state_t;

  state_t          state;
  state_t          state_next;
  logic [COLS-1:0] mat [ROWS];
  logic [AW-1:0]   col;
  logic [AW-1:0]   row;
  logic [AW-1:0]   piv;
  logic            success_r;
  logic            fail_r;
  logic            done_r;
  logic [COLS-1:0] rd_data;

  logic ready;
  logic accept;
  logic pivot_hit;
  logic wr_ok;
  logic rd_ok;

  // done is registered from FIN, so the cycle in which it is high is still
  // treated as busy: a start or write arriving alongside done is dropped.
  assign ready     = (state == IDLE) && !done_r;
  assign accept    = ready && bus.start;
  assign pivot_hit = mat[row][CW'(col)];
  assign wr_ok     = {1'b0, bus.wr_addr} < (AW+1)'(ROWS);
  assign rd_ok     = {1'b0, bus.rd_addr} < (AW+1)'(ROWS);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (accept) state_next = SEARCH;
      SEARCH: begin
        if (pivot_hit)        state_next = SWAP;
        else if (row == LAST) state_next = FIN;
      end
      SWAP:   state_next = ELIM;
      ELIM:   state_next = (col == LAST) ? FIN : SEARCH;
      FIN:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.busy     = (state != IDLE) || done_r;
    bus.done     = done_r;
    bus.success  = success_r;
    bus.fail     = fail_r;
    bus.data_out = rd_data;
  end

  // Matrix storage, pivot counters, status flags and the read port.
  // A read sees the row as it was before any same-cycle write/swap/elim,
  // which falls out of the non-blocking updates below.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROWS; i++) mat[i] <= '0;
      col       <= '0;
      row       <= '0;
      piv       <= '0;
      success_r <= 1'b0;
      fail_r    <= 1'b0;
      done_r    <= 1'b0;
      rd_data   <= '0;
    end else begin
      done_r <= (state == FIN);

      if (bus.rd_en) rd_data <= rd_ok ? mat[bus.rd_addr] : '0;

      case (state)
        IDLE: begin
          if (ready && bus.wr_en && wr_ok) mat[bus.wr_addr] <= bus.data_in;
          if (accept) begin
            success_r <= 1'b0;
            fail_r    <= 1'b0;
            col       <= '0;
            row       <= '0;
          end
        end
        SEARCH: begin
          if (pivot_hit)        piv    <= row;
          else if (row == LAST) fail_r <= 1'b1;
          else                  row    <= row + 1'b1;
        end
        SWAP: begin
          mat[piv] <= mat[col];
          mat[col] <= mat[piv];
        end
        ELIM: begin
          // Clear the pivot column in every other row at once; the full row
          // width is XORed so the tail columns follow the reduction.
          for (int i = 0; i < ROWS; i++) begin
            if ((AW'(i) != col) && mat[i][CW'(col)]) mat[i] <= mat[i] ^ mat[col];
          end
          if (col == LAST) begin
            success_r <= 1'b1;
          end else begin
            col <= col + 1'b1;
            row <= col + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gf2_row_systemizer.sv
// tb_gf2_row_systemizer: self-checking bench for gf2_row_systemizer. A
// behavioural Gaussian-elimination model on a plain array predicts the final
// matrix, the success/fail outcome and the start-to-done latency. A second,
// smaller instance (6 rows) exercises out-of-range addresses.
module tb_gf2_row_systemizer;

  localparam int ROWS  = 8;
  localparam int COLS  = 10;
  localparam int AW    = 3;
  localparam int ROWS2 = 6;
  localparam int COLS2 = 8;
  localparam int AW2   = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gf2_row_systemizer_if #(.ROWS(ROWS),  .COLS(COLS),  .AW(AW))  bus  ();
  gf2_row_systemizer_if #(.ROWS(ROWS2), .COLS(COLS2), .AW(AW2)) bus2 ();

  gf2_row_systemizer #(.ROWS(ROWS), .COLS(COLS), .AW(AW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  gf2_row_systemizer #(.ROWS(ROWS2), .COLS(COLS2), .AW(AW2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  int checks   = 0;
  int failures = 0;

  logic [COLS-1:0] ref_mat [ROWS];
  logic            exp_ok;
  int              exp_lat;
  int              fail_col;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_row(input int a, input logic [COLS-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(a);
    bus.data_in = d;
    @(posedge clk); #1;
    bus.wr_en   = 1'b0;
  endtask

  task automatic read_row(input int a, output logic [COLS-1:0] d);
    bus.rd_en   = 1'b1;
    bus.rd_addr = AW'(a);
    @(posedge clk); #1;
    bus.rd_en   = 1'b0;
    d = bus.data_out;
  endtask

  task automatic load_ref();
    for (int i = 0; i < ROWS; i++) write_row(i, ref_mat[i]);
  endtask

  // Textbook elimination on ref_mat; cycle cost is one per candidate row
  // examined plus swap and eliminate, and done appears one cycle after the
  // last working cycle.
  task automatic model_run();
    logic [COLS-1:0] t;
    int p;
    int cyc;
    cyc      = 0;
    exp_ok   = 1'b1;
    fail_col = ROWS;
    for (int c = 0; c < ROWS; c++) begin
      p = -1;
      for (int r = c; r < ROWS; r++) if (p < 0 && ref_mat[r][c]) p = r;
      if (p < 0) begin
        cyc += ROWS - c;
        exp_ok   = 1'b0;
        fail_col = c;
        break;
      end
      cyc += (p - c + 1) + 2;
      t = ref_mat[p]; ref_mat[p] = ref_mat[c]; ref_mat[c] = t;
      for (int i = 0; i < ROWS; i++) if (i != c && ref_mat[i][c]) ref_mat[i] ^= ref_mat[c];
    end
    exp_lat = cyc + 1;
  endtask

  // Starts a run, optionally pokes a write and a second start mid-run,
  // measures latency to done, checks status and the resulting rows.
  task automatic apply_stimulus(input string tag, input bit poke);
    int lat;
    logic [COLS-1:0] d;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({tag, ":busy"}, 32'(bus.busy), 1);
    lat = 0;
    while (!bus.done && lat < 300) begin
      if (poke && lat == 4) begin
        bus.wr_en = 1'b1; bus.wr_addr = '0; bus.data_in = '1; bus.start = 1'b1;
      end
      @(posedge clk); #1;
      lat++;
      bus.wr_en = 1'b0; bus.start = 1'b0;
    end
    check({tag, ":latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ":success"}, 32'(bus.success), 32'(exp_ok));
    check({tag, ":fail"},    32'(bus.fail),    32'(!exp_ok));
    // start alongside done must be dropped
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({tag, ":done_pulse"}, 32'(bus.done), 0);
    check({tag, ":busy_after"}, 32'(bus.busy), 0);
    check({tag, ":success_held"}, 32'(bus.success), 32'(exp_ok));
    check_output(tag);
  endtask

  task automatic check_output(input string tag);
    logic [COLS-1:0] d;
    for (int i = 0; i < (exp_ok ? ROWS : fail_col); i++) begin
      read_row(i, d);
      check($sformatf("%s:row%0d", tag, i), 32'(d), 32'(ref_mat[i]));
    end
  endtask

  initial begin
    logic [COLS-1:0]  d;
    int               a;
    int               b;
    logic [COLS-1:0]  t;

    rst = 1'b1;
    bus.start = 0; bus.wr_en = 0; bus.wr_addr = '0; bus.data_in = '0; bus.rd_en = 0; bus.rd_addr = '0;
    bus2.start = 0; bus2.wr_en = 0; bus2.wr_addr = '0; bus2.data_in = '0; bus2.rd_en = 0; bus2.rd_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    $display("[TB] reset released");

    check("rst:busy",     32'(bus.busy), 0);
    check("rst:done",     32'(bus.done), 0);
    check("rst:success",  32'(bus.success), 0);
    check("rst:fail",     32'(bus.fail), 0);
    check("rst:data_out", 32'(bus.data_out), 0);
    read_row(3, d);
    check("rst:row3", 32'(d), 0);

    // Identity with tail bits: 3*ROWS working cycles, then done.
    for (int i = 0; i < ROWS; i++) ref_mat[i] = COLS'(1 << i) | 10'h300;
    load_ref(); model_run();
    check("ident:model_lat", 32'(exp_lat), 25);
    apply_stimulus("ident", 1'b0);

    // Same matrix again with a write and a start injected mid-run.
    for (int i = 0; i < ROWS; i++) ref_mat[i] = COLS'(1 << i) | 10'h300;
    load_ref(); model_run();
    apply_stimulus("guard", 1'b1);

    // Column 0 pivot lives in row 1.
    for (int i = 0; i < ROWS; i++) ref_mat[i] = COLS'(1 << i);
    ref_mat[0] = 10'h002; ref_mat[1] = 10'h001;
    load_ref(); model_run();
    apply_stimulus("swap", 1'b0);

    // Elimination propagates into the tail columns.
    for (int i = 1; i < ROWS; i++) ref_mat[i] = COLS'(1 << i) | 10'h100;
    ref_mat[0] = 10'h3FF;
    load_ref(); model_run();
    apply_stimulus("tail", 1'b0);

    // Column 3 empty: singular.
    for (int i = 0; i < ROWS; i++) ref_mat[i] = COLS'(1 << i);
    ref_mat[3] = 10'h300;
    load_ref(); model_run();
    check("sing:model_lat", 32'(exp_lat), 15);
    apply_stimulus("sing", 1'b0);

    // Random invertible matrices built from identity by row operations.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < ROWS; i++) ref_mat[i] = COLS'(1 << i) | (COLS'($urandom) & 10'h300);
      for (int n = 0; n < 14; n++) begin
        a = $urandom_range(0, ROWS-1);
        b = $urandom_range(0, ROWS-1);
        if (a != b) begin
          if ($urandom_range(0, 1) == 0) ref_mat[a] ^= ref_mat[b];
          else begin t = ref_mat[a]; ref_mat[a] = ref_mat[b]; ref_mat[b] = t; end
        end
      end
      load_ref(); model_run();
      apply_stimulus($sformatf("rinv%0d", k), 1'b0);
    end

    // Fully random matrices (singular or not).
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < ROWS; i++) ref_mat[i] = COLS'($urandom);
      load_ref(); model_run();
      apply_stimulus($sformatf("rand%0d", k), 1'b0);
    end

    // Read in the same cycle as a write returns the old row.
    write_row(5, 10'h155);
    bus.wr_en = 1'b1; bus.wr_addr = 3'd5; bus.data_in = 10'h2AA;
    bus.rd_en = 1'b1; bus.rd_addr = 3'd5;
    @(posedge clk); #1;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    check("rw:pre_update", 32'(bus.data_out), 32'h155);
    @(posedge clk); #1;
    check("rw:hold", 32'(bus.data_out), 32'h155);
    read_row(5, d);
    check("rw:post_update", 32'(d), 32'h2AA);

    // Out-of-range addresses on the 6-row instance.
    for (int i = 0; i < ROWS2; i++) begin
      bus2.wr_en = 1'b1; bus2.wr_addr = AW2'(i); bus2.data_in = COLS2'(8'h11 * (i + 1));
      @(posedge clk); #1;
    end
    bus2.wr_addr = 3'd6; bus2.data_in = 8'hFF;
    @(posedge clk); #1;
    bus2.wr_addr = 3'd7; bus2.data_in = 8'hEE;
    @(posedge clk); #1;
    bus2.wr_en = 1'b0;
    for (int i = 0; i < ROWS2; i++) begin
      bus2.rd_en = 1'b1; bus2.rd_addr = AW2'(i);
      @(posedge clk); #1;
      check($sformatf("oor:row%0d", i), 32'(bus2.data_out), 32'(8'h11 * (i + 1)));
    end
    bus2.rd_addr = 3'd6;
    @(posedge clk); #1;
    check("oor:read6", 32'(bus2.data_out), 0);
    bus2.rd_addr = 3'd7;
    @(posedge clk); #1;
    bus2.rd_en = 1'b0;
    check("oor:read7", 32'(bus2.data_out), 0);

    // Reset asserted during the first ELIM cycle aborts the run.
    for (int i = 0; i < ROWS; i++) write_row(i, COLS'(1 << i) | 10'h300);
    read_row(1, d);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("mid_rst:busy",     32'(bus.busy), 0);
    check("mid_rst:data_out", 32'(bus.data_out), 0);
    repeat (3) begin
      @(posedge clk); #1;
      check("mid_rst:done", 32'(bus.done), 0);
    end
    rst = 1'b0;
    check("mid_rst:success", 32'(bus.success), 0);
    check("mid_rst:fail",    32'(bus.fail), 0);
    read_row(0, d);
    check("mid_rst:row0_cleared", 32'(d), 0);

    for (int i = 0; i < ROWS; i++) ref_mat[i] = COLS'(1 << i);
    ref_mat[0] = 10'h002; ref_mat[1] = 10'h001;
    load_ref(); model_run();
    apply_stimulus("post_rst", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
